tone_sequencer: RTL and testbench

- Queues tone requests (sound code + duration) from the game FSM and sequences the play/sound controls of the speaker tone generator.
- Each tone is followed by a fixed silent gap; back-to-back tones play with no extra idle cycles.
- Sits between the game FSM (requester) and the tone generator (consumer). It replaces ad-hoc per-state count/play bookkeeping in the game FSM.

---
 rtl/tone_pkg.sv | 19 +
 rtl/tone_fifo.sv | 49 ++++
 rtl/tone_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types for the tone sequencer: sound codes, sequencer states, sound field type.
package tone_pkg;

    typedef logic [2:0] sound_t;

    localparam sound_t RED    = 3'd0;
    localparam sound_t GREEN  = 3'd1;
    localparam sound_t YELLOW = 3'd2;
    localparam sound_t BLUE   = 3'd3;
    localparam sound_t S_WIN  = 3'd4;
    localparam sound_t S_LOSS = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_t;

endpackage

// File: rtl/tone_fifo.sv
// Synchronous request FIFO with flush; occupancy is the write/read pointer difference.
module tone_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_level = r_wptr - r_rptr;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (o_level == '0);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/tone_sequencer.sv
// Queues tone requests and drives play/sound of the tone generator, with a silent gap after each tone.
// Optional priority-tone preemption is enabled by defining TONE_PRIO_EN.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DUR_W      = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_sound,
    input  logic [DUR_W-1:0]        req_dur,
    input  logic                    flush,
`ifdef TONE_PRIO_EN
    input  logic                    prio_valid,
    input  logic [2:0]              prio_sound,
    input  logic [DUR_W-1:0]        prio_dur,
`endif
    output logic                    play,
    output logic [2:0]              sound,
    output logic                    busy,
    output logic                    seq_done,
    output logic [$clog2(DEPTH):0]  level
);

    typedef struct packed {
        sound_t           sound;
        logic [DUR_W-1:0] dur;
    } entry_t;

    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [DUR_W-1:0] GAP_LOAD = HAS_GAP ? DUR_W'(GAP_CYCLES - 1) : '0;

    state_t           r_state, w_state_nxt;
    logic [DUR_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_play, w_play_nxt;
    sound_t           r_sound, w_sound_nxt;
    logic             r_done, w_done_nxt;
    logic             w_pop, w_try_pop, w_drain;
    logic             w_full, w_empty;
    entry_t           w_head, w_push_data;
    logic             w_prio;
    sound_t           w_prio_sound;
    logic [DUR_W-1:0] w_prio_dur;

`ifdef TONE_PRIO_EN
    assign w_prio       = prio_valid;
    assign w_prio_sound = prio_sound;
    assign w_prio_dur   = prio_dur;
`else
    assign w_prio       = 1'b0;
    assign w_prio_sound = '0;
    assign w_prio_dur   = '0;
`endif

    assign req_ready   = !w_full && !flush && !w_prio;
    assign w_push_data = '{sound: req_sound, dur: req_dur};

    tone_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (req_valid && req_ready),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (flush || w_prio),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // w_try_pop marks a point where the next entry may start; w_drain marks the end of a busy run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_play_nxt  = r_play;
        w_sound_nxt = r_sound;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_try_pop   = 1'b0;
        w_drain     = 1'b0;

        if (flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_play_nxt  = 1'b0;
            w_sound_nxt = RED;
        end else if (w_prio) begin
            w_state_nxt = TONE;
            w_play_nxt  = 1'b1;
            w_sound_nxt = w_prio_sound;
            w_cnt_nxt   = (w_prio_dur == '0) ? '0 : w_prio_dur - DUR_W'(1);
        end else begin
            case (r_state)
                IDLE: w_try_pop = 1'b1;
                TONE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - DUR_W'(1);
                    end else if (HAS_GAP) begin
                        w_state_nxt = GAP;
                        w_play_nxt  = 1'b0;
                        w_cnt_nxt   = GAP_LOAD;
                    end else begin
                        w_try_pop = 1'b1;
                        w_drain   = 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - DUR_W'(1);
                    end else begin
                        w_try_pop = 1'b1;
                        w_drain   = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            if (w_try_pop) begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.dur == '0) begin
                        w_state_nxt = IDLE;
                        w_play_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = TONE;
                        w_play_nxt  = 1'b1;
                        w_sound_nxt = w_head.sound;
                        w_cnt_nxt   = w_head.dur - DUR_W'(1);
                    end
                end else if (w_drain) begin
                    w_state_nxt = IDLE;
                    w_play_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_play  <= 1'b0;
            r_sound <= RED;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_play  <= w_play_nxt;
            r_sound <= w_sound_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign play     = r_play;
    assign sound    = r_sound;
    assign seq_done = r_done;
    assign busy     = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_tone_sequencer;
    import tone_pkg::*;

    localparam int DEPTH      = 4;
    localparam int DUR_W      = 6;
    localparam int GAP_CYCLES = 2;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_sound = '0;
    logic [DUR_W-1:0]  req_dur = '0;
    logic              flush = 1'b0;
    logic              play;
    logic [2:0]        sound;
    logic              busy;
    logic              seq_done;
    logic [LW-1:0]     level;
    logic              tb_pv = 1'b0;
    logic [2:0]        tb_ps = '0;
    logic [DUR_W-1:0]  tb_pd = '0;

    int errors = 0;
    int checks = 0;

    tone_sequencer #(
        .DEPTH      (DEPTH),
        .DUR_W      (DUR_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sound  (req_sound),
        .req_dur    (req_dur),
        .flush      (flush),
`ifdef TONE_PRIO_EN
        .prio_valid (tb_pv),
        .prio_sound (tb_ps),
        .prio_dur   (tb_pd),
`endif
        .play       (play),
        .sound      (sound),
        .busy       (busy),
        .seq_done   (seq_done),
        .level      (level)
    );

    always #5 clock = ~clock;

    // Reference model: pending requests, remaining play cycles and remaining gap cycles.
    typedef struct {
        logic [2:0] snd;
        int         dur;
    } req_t;

    req_t       q[$];
    int         m_p = 0;
    int         m_g = 0;
    bit         m_active = 0;
    bit         m_done = 0;
    logic [2:0] m_sound = '0;

    function automatic logic [8:0] model_vec();
        return {(m_p > 0), m_sound, m_done, (m_active || q.size() != 0), LW'(q.size())};
    endfunction

    function automatic bit model_ready(input bit fl, input bit pv);
        return (q.size() < DEPTH) && !fl && !pv;
    endfunction

    task automatic model_edge(input bit rst, input bit rv, input logic [2:0] rs, input int rd,
                              input bit fl, input bit pv, input logic [2:0] ps, input int pd);
        bit   acc;
        bit   free;
        req_t h;
        acc    = rv && model_ready(fl, pv);
        m_done = 0;
        free   = 0;
        if (rst || fl) begin
            q.delete();
            m_p = 0; m_g = 0; m_active = 0; m_sound = '0;
            return;
        end
        if (pv) begin
            q.delete();
            m_p = (pd == 0) ? 1 : pd; m_g = 0; m_sound = ps; m_active = 1;
            return;
        end
        if (m_p > 0) begin
            m_p--;
            if (m_p == 0) begin
                m_g  = GAP_CYCLES;
                free = (m_g == 0);
            end
        end else if (m_g > 0) begin
            m_g--;
            free = (m_g == 0);
        end else begin
            free = 1;
        end
        if (free) begin
            if (q.size() != 0) begin
                h = q.pop_front();
                if (h.dur == 0) begin
                    m_active = 0;
                end else begin
                    m_p = h.dur; m_sound = h.snd; m_active = 1;
                end
            end else if (m_active) begin
                m_done   = 1;
                m_active = 0;
            end
        end
        if (acc) q.push_back('{rs, rd});
    endtask

    task automatic drive(input bit v, input logic [2:0] s, input int d, input bit f);
        req_valid = v;
        req_sound = s;
        req_dur   = DUR_W'(d);
        flush     = f;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(reset, req_valid, req_sound, int'(req_dur), flush, tb_pv, tb_ps, int'(tb_pd));
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 3'd4, 5, 0);
        step();
        step();
        checks++;
        if ({play, sound, seq_done, busy, level} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {play, sound, seq_done, busy, level}, 9'b0);
        end
        checks++;
        if ({play, sound, seq_done, busy, level} !== model_vec()) begin
            errors++;
            $display("FAIL reset_model got=%b exp=%b", {play, sound, seq_done, busy, level}, model_vec());
        end
        reset = 1'b0;
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_single();
        int plays = 0;
        int dones = 0;
        drive(1, 3'd2, 3, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) drive(0, 0, 0, 0);
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL single_cycle%0d got=%b exp=%b", i, {play, sound, seq_done, busy, level}, model_vec());
            end
            if (play && sound == 3'd2) plays++;
            if (seq_done) dones++;
        end
        checks++;
        if (plays !== 3) begin errors++; $display("FAIL single_play_len got=%0d exp=3", plays); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", dones); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  snd [3];
        int          dur [3];
        logic [10:0] pattern = '0;
        logic [10:0] exp_pattern;
        int          dones = 0;
        snd = '{3'd0, 3'd1, 3'd3};
        dur = '{2, 2, 1};
        exp_pattern = 11'b11001100100;
        for (int i = 0; i < 16; i++) begin
            if (i < 3) drive(1, snd[i], dur[i], 0);
            else drive(0, 0, 0, 0);
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL b2b_cycle%0d got=%b exp=%b", i, {play, sound, seq_done, busy, level}, model_vec());
            end
            if (i >= 1 && i <= 11) pattern = {pattern[9:0], play};
            if (seq_done) dones++;
        end
        checks++;
        if (pattern !== exp_pattern) begin
            errors++; $display("FAIL b2b_pattern got=%b exp=%b", pattern, exp_pattern);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_full();
        int waited;
        int cyc = 0;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            drive(1, 3'(k), 10, 0);
            while (!req_ready && waited < 100) begin
                checks++;
                if (level !== LW'(DEPTH)) begin
                    errors++; $display("FAIL full_level_when_blocked got=%0d exp=%0d", level, DEPTH);
                end
                step();
                checks++;
                if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                    errors++;
                    $display("FAIL full_wait got=%b exp=%b", {play, sound, seq_done, busy, level}, model_vec());
                end
                waited++;
            end
            checks++;
            if (waited >= 100) begin errors++; $display("FAIL full_timeout push=%0d got=blocked exp=accepted", k); end
            checks++;
            if ((k == 5) !== (waited > 0)) begin
                errors++; $display("FAIL full_hold push=%0d got_waited=%0d exp_held=%0d", k, waited, (k == 5));
            end
            checks++;
            if (req_ready !== model_ready(0, 0)) begin
                errors++; $display("FAIL full_ready got=%b exp=%b", req_ready, model_ready(0, 0));
            end
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL full_push%0d got=%b exp=%b", k, {play, sound, seq_done, busy, level}, model_vec());
            end
        end
        drive(0, 0, 0, 0);
        while (busy && cyc < 200) begin
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL full_drain got=%b exp=%b", {play, sound, seq_done, busy, level}, model_vec());
            end
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL full_drain_timeout got=busy exp=idle"); end
        step();
    endtask

    task automatic test_zero_dur();
        int plays = 0;
        int code1 = 0;
        int dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) drive(1, 3'd1, 0, 0);
            else if (i == 1) drive(1, 3'd2, 2, 0);
            else drive(0, 0, 0, 0);
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL zero_cycle%0d got=%b exp=%b", i, {play, sound, seq_done, busy, level}, model_vec());
            end
            if (play && sound == 3'd1) code1++;
            if (play && sound == 3'd2) plays++;
            if (seq_done) dones++;
        end
        checks++;
        if (code1 !== 0) begin errors++; $display("FAIL zero_skipped got=%0d exp=0", code1); end
        checks++;
        if (plays !== 2) begin errors++; $display("FAIL zero_next_len got=%0d exp=2", plays); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_flush();
        int dones = 0;
        drive(1, 3'd0, 8, 0); step();
        drive(1, 3'd1, 3, 0); step();
        drive(1, 3'd2, 3, 0); step();
        drive(1, 3'd3, 3, 1); step();
        checks++;
        if ({play, sound, seq_done, busy, level} !== 9'b0) begin
            errors++; $display("FAIL flush_outputs got=%b exp=%b", {play, sound, seq_done, busy, level}, 9'b0);
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL flush_after got=%b exp=%b", {play, sound, seq_done, busy, level}, model_vec());
            end
            if (seq_done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    endtask

`ifdef TONE_PRIO_EN
    task automatic test_prio();
        int s5 = 0;
        int dones = 0;
        drive(1, 3'd0, 5, 0); step();
        drive(1, 3'd1, 5, 0); step();
        drive(1, 3'd2, 5, 0); step();
        tb_pv = 1'b1; tb_ps = 3'd5; tb_pd = 6'd4;
        drive(1, 3'd3, 3, 0);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got=%b exp=0", req_ready); end
        step();
        tb_pv = 1'b0;
        drive(0, 0, 0, 0);
        checks++;
        if ({play, sound, level} !== {1'b1, 3'd5, LW'(0)}) begin
            errors++; $display("FAIL prio_start got=%b exp=%b", {play, sound, level}, {1'b1, 3'd5, LW'(0)});
        end
        s5 = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL prio_cycle%0d got=%b exp=%b", i, {play, sound, seq_done, busy, level}, model_vec());
            end
            if (play && sound == 3'd5) s5++;
            if (seq_done) dones++;
        end
        checks++;
        if (s5 !== 4 || dones !== 1) begin
            errors++; $display("FAIL prio_len_done got=%0d/%0d exp=4/1", s5, dones);
        end
    endtask
`endif

    task automatic test_random();
        bit pre_ready;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
`ifdef TONE_PRIO_EN
            tb_pv = ($urandom_range(0, 49) == 0);
            tb_ps = 3'($urandom);
            tb_pd = DUR_W'($urandom_range(0, 4));
`endif
            drive($urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(1, 6), $urandom_range(0, 39) == 0);
            pre_ready = model_ready(flush, tb_pv);
            if (!reset) begin
                checks++;
                if (req_ready !== pre_ready) begin
                    errors++; $display("FAIL rand_ready cycle%0d got=%b exp=%b", i, req_ready, pre_ready);
                end
            end
            step();
            checks++;
            if ({play, sound, seq_done, busy, level} !== model_vec()) begin
                errors++;
                $display("FAIL rand_cycle%0d got=%b exp=%b", i, {play, sound, seq_done, busy, level}, model_vec());
            end
        end
        reset = 1'b0;
        tb_pv = 1'b0;
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_zero_dur();
        test_flush();
`ifdef TONE_PRIO_EN
        test_prio();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
